// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames,
// checks start/parity/stop and folds F0/E0 prefixes into break/ext flags.
module ps2_rx_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err,
    output logic       dbg_state,
    output logic [3:0] dbg_bit_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    logic          clk_s1_q, clk_s1_d;
    logic          clk_s2_q, clk_s2_d;
    logic          clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d;
    logic          dat_s2_q, dat_s2_d;
    logic [0:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   frame_q, frame_d;
    logic          eval_q, eval_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_break_q, key_break_d;
    logic          key_ext_q, key_ext_d;
    logic          frame_err_q, frame_err_d;

    logic       fall_tick;
    logic       frame_ok;
    logic [7:0] frame_byte;

    assign fall_tick  = clk_prev_q & ~clk_s2_q;
    assign frame_byte = frame_q[8:1];
    // Odd parity over data plus parity bit; start low, stop high.
    assign frame_ok   = ~frame_q[0] & (^frame_q[9:1]) & frame_q[10];

    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        clk_prev_d  = clk_s2_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        eval_d      = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        brk_pend_d  = brk_pend_q;
        ext_pend_d  = ext_pend_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (fall_tick) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 4'd1;
                    frame_d   = {dat_s2_q, frame_q[10:1]};
                end
            end
            ST_RECV: begin
                // A falling edge beats a simultaneous timeout.
                if (fall_tick) begin
                    frame_d   = {dat_s2_q, frame_q[10:1]};
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 4'd0;
                        eval_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_cnt_q == TMO_MAX) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = 4'd0;
                    tmo_cnt_d   = '0;
                    frame_err_d = 1'b1;
                    brk_pend_d  = 1'b0;
                    ext_pend_d  = 1'b0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
                tmo_cnt_d = '0;
            end
        endcase

        // The captured frame is judged one cycle after the stop bit lands.
        if (eval_q) begin
            if (!frame_ok) begin
                frame_err_d = 1'b1;
                brk_pend_d  = 1'b0;
                ext_pend_d  = 1'b0;
            end else if (frame_byte == CODE_BRK) begin
                brk_pend_d = 1'b1;
            end else if (frame_byte == CODE_EXT) begin
                ext_pend_d = 1'b1;
            end else begin
                key_code_d  = frame_byte;
                key_break_d = brk_pend_q;
                key_ext_d   = ext_pend_q;
                key_valid_d = 1'b1;
                brk_pend_d  = 1'b0;
                ext_pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            frame_q     <= 11'd0;
            eval_q      <= 1'b0;
            tmo_cnt_q   <= '0;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            key_code_q  <= 8'd0;
            key_valid_q <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            eval_q      <= eval_d;
            tmo_cnt_q   <= tmo_cnt_d;
            brk_pend_q  <= brk_pend_d;
            ext_pend_q  <= ext_pend_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_break   = key_break_q;
    assign key_ext     = key_ext_q;
    assign frame_err   = frame_err_q;
    assign dbg_state   = state_q;
    assign dbg_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: a driver shapes PS/2 frames, a monitor
// pops expected key events / errors from a queue and checks value and cycle.
module tb_ps2_rx_decoder;

    localparam int T    = 1000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_break;
    logic       key_ext;
    logic       frame_err;
    logic       dbg_state;
    logic [3:0] dbg_bit_cnt;

    ps2_rx_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_break  (key_break),
        .key_ext    (key_ext),
        .frame_err  (frame_err),
        .dbg_state  (dbg_state),
        .dbg_bit_cnt(dbg_bit_cnt)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: entry = {is_err, code, brk, ext}
    logic [10:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        m_brk = 1'b0;
    logic        m_ext = 1'b0;
    logic [7:0]  m_last = 8'h00;
    int          last_fall_cyc = 0;
    logic        prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_key_code"},  {24'd0, key_code}, 32'd0);
        chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
        chk({tag, "_key_break"}, {31'd0, key_break}, 32'd0);
        chk({tag, "_key_ext"},   {31'd0, key_ext}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_state"},     {31'd0, dbg_state}, 32'd0);
        chk({tag, "_bit_cnt"},   {28'd0, dbg_bit_cnt}, 32'd0);
    endtask

    // driver: sends nbits of a frame; pushes the expected outcome at the stop edge
    task automatic send_frame(input logic [7:0] b, input logic start_b, input logic par_flip,
                              input logic stop_b, input int nbits);
        logic [10:0] fr;
        logic        good;
        fr   = {stop_b, (~^b) ^ par_flip, b, start_b};
        good = !start_b && !par_flip && stop_b;
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF) @(negedge clk);
            ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) begin
                if (!good) begin
                    exp_q.push_back({1'b1, 8'h00, 1'b0, 1'b0});
                    exp_cyc_q.push_back(cyc + 4);
                    m_brk = 1'b0;
                    m_ext = 1'b0;
                end else if (b == 8'hF0) begin
                    m_brk = 1'b1;
                end else if (b == 8'hE0) begin
                    m_ext = 1'b1;
                end else begin
                    exp_q.push_back({1'b0, b, m_brk, m_ext});
                    exp_cyc_q.push_back(cyc + 4);
                    m_last = b;
                    m_brk  = 1'b0;
                    m_ext  = 1'b0;
                end
            end
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b1, 11);
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid || frame_err) begin
                logic [10:0] e;
                int          c;
                chk("strobe_overlap", {31'd0, key_valid & frame_err}, 32'd0);
                chk("strobe_gap", {31'd0, prev_strobe}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, key_valid, frame_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    chk("kind_is_err", {31'd0, frame_err}, {31'd0, e[10]});
                    chk("latency_cycle", cyc, c);
                    if (!e[10]) begin
                        chk("key_code",  {24'd0, key_code}, {24'd0, e[9:2]});
                        chk("key_break", {31'd0, key_break}, {31'd0, e[1]});
                        chk("key_ext",   {31'd0, key_ext}, {31'd0, e[0]});
                    end
                end
            end
            prev_strobe <= key_valid | frame_err;
        end else begin
            prev_strobe <= 1'b0;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // make code
        good_frame(8'h1C);
        repeat (40) @(negedge clk);

        // break then make
        good_frame(8'hF0);
        good_frame(8'h1C);
        good_frame(8'h1C);
        repeat (40) @(negedge clk);

        // extended release
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h75);
        repeat (40) @(negedge clk);

        // parity error keeps key_code
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11);
        repeat (40) @(negedge clk);
        chk("key_code_held", {24'd0, key_code}, {24'd0, m_last});

        // F0 then bad frame clears pending break
        good_frame(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 11);
        good_frame(8'h1C);
        repeat (40) @(negedge clk);

        // bad stop, bad start with pending extended prefix
        send_frame(8'h2A, 1'b0, 1'b0, 1'b0, 11);
        good_frame(8'hE0);
        send_frame(8'h2A, 1'b1, 1'b0, 1'b1, 11);
        good_frame(8'h2A);
        repeat (40) @(negedge clk);

        // timeout after 5 bits with a pending break
        good_frame(8'hF0);
        send_frame(8'h16, 1'b0, 1'b0, 1'b1, 5);
        exp_q.push_back({1'b1, 8'h00, 1'b0, 1'b0});
        exp_cyc_q.push_back(last_fall_cyc + 4 + T);
        m_brk = 1'b0;
        m_ext = 1'b0;
        repeat (T + 40) @(negedge clk);
        chk("timeout_state_idle", {31'd0, dbg_state}, 32'd0);
        good_frame(8'h16);
        repeat (40) @(negedge clk);

        // reset mid-frame
        good_frame(8'hE0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 7);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_last = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        good_frame(8'h1C);
        repeat (50) @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
